stall_flush_ctrl: RTL
=====================

STALL_FLUSH_CTRL -- requirements
Module: stall_flush_ctrl

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 4, total EX-stage occupancy of a multiply (legal 2..16).
REQ-002 SHALL have parameter MEM_TIMEOUT, default 255, MEM_WAIT cycle limit before error (legal 1..255).
REQ-003 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port load_use_hazard  in  1  load-use stall request from hazard detection.
REQ-006 SHALL have port branch_taken  in  1  branch resolved taken in EX.
REQ-007 SHALL have port mul_start  in  1  multiply instruction in EX, first cycle.
REQ-008 SHALL have port mem_req / mem_ack  in  1 each  MEM-stage data-memory request / completion.
REQ-009 SHALL have ports PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write  out  1 each  stage register write enables.
REQ-010 SHALL have ports IF_ID_Flush, ID_EX_Flush, EX_MEM_Bubble, MEM_WB_Bubble  out  1 each  bubble/flush insertion.
REQ-011 SHALL have ports mem_busy  out  1  (state == MEM_WAIT); mem_err  out  1  sticky timeout flag; stall_cnt  out  16  stall cycle count.

Function
REQ-012 SHALL implement states RUN, MEM_WAIT, MUL_WAIT; outputs combinational from state, counters, inputs.
REQ-013 Default (no condition): all *_Write = 1, all flush/bubble = 0.
REQ-014 "mem stall" = mem_req && !mem_ack; in any state it SHALL force full freeze: all four *_Write = 0, MEM_WB_Bubble = 1, other flushes 0; highest priority.
REQ-015 RUN + mem stall SHALL go to MEM_WAIT; MEM_WAIT holds until mem_ack = 1; that cycle outputs default, next state RUN.
REQ-016 MEM_WAIT SHALL count cycles in an 8-bit counter (cleared on entry); reaching MEM_TIMEOUT SHALL set mem_err = 1, held until reset; state unaffected.
REQ-017 RUN + mul_start (no mem stall) SHALL assert PCWrite = IF_ID_Write = ID_EX_Write = 0, EX_MEM_Bubble = 1, load 4-bit mul counter with MUL_CYCLES-1, go to MUL_WAIT.
REQ-018 MUL_WAIT SHALL decrement counter each cycle while > 1 (also during mem stall); freeze of REQ-017 while counter > 1; counter == 1 and no mem stall: default outputs, next RUN; counter == 1 with mem stall: hold.
REQ-019 mul_start SHALL be ignored outside RUN.
REQ-020 RUN + branch_taken (no mem stall, no mul_start) SHALL assert IF_ID_Flush = ID_EX_Flush = 1 for that cycle; write enables stay 1.
REQ-021 RUN + load_use_hazard (no mem stall/mul_start/branch_taken) SHALL assert PCWrite = IF_ID_Write = 0, ID_EX_Flush = 1.
REQ-022 Priority: mem stall > mul_start > branch_taken > load_use_hazard; lower requests ignored in that cycle; branch_taken and load_use_hazard ignored in MEM_WAIT and MUL_WAIT.

Reset
REQ-023 rst SHALL immediately set state RUN, counters 0, mem_err 0, stall_cnt 0, independent of clk.
REQ-024 While rst = 1 outputs SHALL be: all *_Write = 1, flush/bubble 0, mem_busy 0; reset mid-MEM_WAIT/MUL_WAIT abandons the operation.

Configuration
REQ-025 With STALL_CNT_EN defined, stall_cnt SHALL increment by 1 every cycle PCWrite = 0 (rst low), saturating at 16'hFFFF.
REQ-026 Without STALL_CNT_EN, stall_cnt SHALL be constant 0 and no counter register is synthesized; port retained.

Verification
REQ-027 Load-use: load_use_hazard = 1 one cycle in RUN -> PCWrite = 0, IF_ID_Write = 0, ID_EX_Flush = 1 that cycle only; stall_cnt = 1 (STALL_CNT_EN).
REQ-028 Multiply, MUL_CYCLES = 4: mul_start pulse -> freeze exactly 3 cycles (start + 2 MUL_WAIT), default on 4th, state RUN after.
REQ-029 Memory: mem_req = 1, mem_ack after 5 cycles -> full freeze 5 cycles, mem_busy = 1 for cycles 2-5, default on ack cycle, mem_err = 0.
REQ-030 Timeout, MEM_TIMEOUT = 3: mem_req = 1, no ack -> mem_err = 1 after 3 MEM_WAIT cycles, stays 1 after ack; cleared only by rst.
REQ-031 Simultaneous: branch_taken = load_use_hazard = 1 -> only flushes, PCWrite = 1; then mem stall + branch_taken -> full freeze, IF_ID_Flush = 0.
REQ-032 Async reset mid-MUL_WAIT (counter = 2): rst pulse between edges -> outputs default immediately, state RUN, stall_cnt 0.

Source files
------------

// File: rtl/stall_flush_ctrl.sv
// Pipeline stall/flush controller: load-use, branch, multi-cycle multiply and memory-wait handling.
// Optional stall-cycle counter enabled by defining STALL_CNT_EN.
module stall_flush_ctrl #(
  parameter int MUL_CYCLES  = 4,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_use_hazard,
  input  logic        branch_taken,
  input  logic        mul_start,
  input  logic        mem_req,
  input  logic        mem_ack,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic        ID_EX_Write,
  output logic        EX_MEM_Write,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Flush,
  output logic        EX_MEM_Bubble,
  output logic        MEM_WB_Bubble,
  output logic        mem_busy,
  output logic        mem_err,
  output logic [15:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MUL_WAIT = 2'd2
  } state_t;

  localparam logic [3:0] MUL_LOAD_C = 4'(MUL_CYCLES - 1);
  localparam logic [8:0] TIMEOUT_C  = 9'(MEM_TIMEOUT);

  state_t      state_r;
  logic [7:0]  mem_cnt_r;
  logic [3:0]  mul_cnt_r;
  logic        mem_err_r;
  logic        mem_stall_s;

  assign mem_stall_s = mem_req && !mem_ack;
  assign mem_err     = mem_err_r;

  // State, wait counters and sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= RUN;
      mem_cnt_r <= 8'd0;
      mul_cnt_r <= 4'd0;
      mem_err_r <= 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          if (mem_stall_s) begin
            state_r   <= MEM_WAIT;
            mem_cnt_r <= 8'd0;
          end else if (mul_start) begin
            state_r   <= MUL_WAIT;
            mul_cnt_r <= MUL_LOAD_C;
          end
        end
        MEM_WAIT: begin
          if (mem_ack) begin
            state_r <= RUN;
          end else begin
            if (mem_cnt_r != 8'hFF) begin
              mem_cnt_r <= mem_cnt_r + 8'd1;
            end
            // 9-bit compare so a saturated counter cannot wrap past the limit
            if (({1'b0, mem_cnt_r} + 9'd1) >= TIMEOUT_C) begin
              mem_err_r <= 1'b1;
            end
          end
        end
        MUL_WAIT: begin
          if (mul_cnt_r > 4'd1) begin
            mul_cnt_r <= mul_cnt_r - 4'd1;
          end else if (!mem_stall_s) begin
            state_r   <= RUN;
            mul_cnt_r <= 4'd0;
          end
        end
        default: begin
          state_r <= RUN;
        end
      endcase
    end
  end

  // Stage enables and bubbles, by priority: mem stall > multiply > branch > load-use
  always_comb begin
    PCWrite       = 1'b1;
    IF_ID_Write   = 1'b1;
    ID_EX_Write   = 1'b1;
    EX_MEM_Write  = 1'b1;
    IF_ID_Flush   = 1'b0;
    ID_EX_Flush   = 1'b0;
    EX_MEM_Bubble = 1'b0;
    MEM_WB_Bubble = 1'b0;
    mem_busy      = 1'b0;
    if (rst) begin
      mem_busy = 1'b0;
    end else begin
      mem_busy = (state_r == MEM_WAIT);
      if (mem_stall_s) begin
        PCWrite       = 1'b0;
        IF_ID_Write   = 1'b0;
        ID_EX_Write   = 1'b0;
        EX_MEM_Write  = 1'b0;
        MEM_WB_Bubble = 1'b1;
      end else begin
        case (state_r)
          RUN: begin
            if (mul_start) begin
              PCWrite       = 1'b0;
              IF_ID_Write   = 1'b0;
              ID_EX_Write   = 1'b0;
              EX_MEM_Bubble = 1'b1;
            end else if (branch_taken) begin
              IF_ID_Flush = 1'b1;
              ID_EX_Flush = 1'b1;
            end else if (load_use_hazard) begin
              PCWrite     = 1'b0;
              IF_ID_Write = 1'b0;
              ID_EX_Flush = 1'b1;
            end else begin
              PCWrite = 1'b1;
            end
          end
          MUL_WAIT: begin
            if (mul_cnt_r > 4'd1) begin
              PCWrite       = 1'b0;
              IF_ID_Write   = 1'b0;
              ID_EX_Write   = 1'b0;
              EX_MEM_Bubble = 1'b1;
            end else begin
              PCWrite = 1'b1;
            end
          end
          MEM_WAIT: begin
            PCWrite = 1'b1;
          end
          default: begin
            PCWrite = 1'b1;
          end
        endcase
      end
    end
  end

`ifdef STALL_CNT_EN
  logic [15:0] stall_cnt_r;

  // Saturating count of cycles with the PC held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= 16'h0000;
    end else if (!PCWrite && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end
  end

  assign stall_cnt = stall_cnt_r;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule
